// File: rtl/layer_store_pkg.sv
// rtl/layer_store_pkg.sv - region tags, store FSM states and default per-layer word counts
package layer_store_pkg;

    localparam logic [3:0] TAG_PIXEL  = 4'b0100;
    localparam logic [3:0] TAG_WEIGHT = 4'b1000;
    localparam logic [3:0] TAG_BIAS   = 4'b1001;
    localparam logic [3:0] TAG_INTR   = 4'b0010;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STORE  = 2'd1,
        S_FINISH = 2'd2
    } store_state_t;

    // Layer i occupies bits [16*i +: 16]
    localparam logic [63:0] DEF_WEIGHT_NUM = {16'd4608, 16'd2304, 16'd1152, 16'd216};
    localparam logic [63:0] DEF_BIAS_NUM   = {16'd64, 16'd32, 16'd16, 16'd8};

endpackage

// File: rtl/region_store_fsm.sv
// rtl/region_store_fsm.sv - one region's layer fill FSM with contiguous addressing and registered write port
module region_store_fsm
    import layer_store_pkg::*;
#(
    parameter int                     DATA_W  = 16,
    parameter int                     ADDR_W  = 16,
    parameter int                     N_LAYER = 4,
    parameter logic [16*N_LAYER-1:0]  COUNTS  = {N_LAYER{16'd1}},
    localparam int                    SEL_W   = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               beat,
    input  logic [DATA_W-1:0]  beat_data,
    output logic               wr,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  data,
    output logic [SEL_W-1:0]   layer_sel,
    output logic [N_LAYER-1:0] layer_done,
    output logic               overflow
);

    function automatic longint total_count();
        longint t = 0;
        for (int i = 0; i < N_LAYER; i++) t += longint'(COUNTS[16*i +: 16]);
        return t;
    endfunction

    localparam longint TOTAL = total_count();

    if (TOTAL > (longint'(1) << ADDR_W)) begin : g_size_chk
        $error("region_store_fsm: total word count exceeds address space");
    end
    for (genvar g = 0; g < N_LAYER; g++) begin : g_cnt_chk
        if (COUNTS[16*g +: 16] == 16'd0) begin : g_zero
            $error("region_store_fsm: layer word count of zero");
        end
    end

    store_state_t      state;
    logic [15:0]       count;
    logic [15:0]       cur_n;
    logic [ADDR_W-1:0] layer_base;
    logic              last_word;
    logic              last_layer;

    always_comb begin
        cur_n = COUNTS[15:0];
        for (int i = 0; i < N_LAYER; i++) begin
            if (layer_sel == SEL_W'(i)) cur_n = COUNTS[16*i +: 16];
        end
    end

    assign last_word  = (count == cur_n - 16'd1);
    assign last_layer = (layer_sel == SEL_W'(N_LAYER - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= S_IDLE;
            count      <= '0;
            layer_sel  <= '0;
            layer_base <= '0;
            wr         <= 1'b0;
            addr       <= '0;
            data       <= '0;
            layer_done <= '0;
            overflow   <= 1'b0;
        end else begin
            wr   <= 1'b0;
            addr <= '0;
            data <= '0;
            if (beat) begin
                if (state == S_FINISH) begin
                    overflow <= 1'b1;
                end else begin
                    wr   <= 1'b1;
                    addr <= layer_base + ADDR_W'(count);
                    data <= beat_data;
                    if (last_word) begin
                        // Done flag rises together with the registered write of the layer's last word
                        layer_done <= layer_done | (N_LAYER'(1) << layer_sel);
                        count      <= '0;
                        if (last_layer) begin
                            state <= S_FINISH;
                        end else begin
                            state      <= S_STORE;
                            layer_sel  <= layer_sel + SEL_W'(1);
                            layer_base <= layer_base + ADDR_W'(cur_n);
                        end
                    end else begin
                        state <= S_STORE;
                        count <= count + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/layer_store_ctrl.sv
// rtl/layer_store_ctrl.sv - decodes bus beats into pixel/weight/bias stores; LAYER_STORE_SOFT_RESTART_EN enables tag-2 restart
module layer_store_ctrl
    import layer_store_pkg::*;
#(
    parameter int                     DATA_W     = 16,
    parameter int                     ADDR_W     = 16,
    parameter int                     N_LAYER    = 4,
    parameter int                     PIXEL_NUM  = 3072,
    parameter logic [16*N_LAYER-1:0]  WEIGHT_NUM = DEF_WEIGHT_NUM,
    parameter logic [16*N_LAYER-1:0]  BIAS_NUM   = DEF_BIAS_NUM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wvalid,
    input  logic [31:0]                awaddr,
    input  logic [31:0]                wdata,
    output logic                       pixel_wr,
    output logic [ADDR_W-1:0]          pixel_addr,
    output logic [DATA_W-1:0]          pixel_data,
    output logic                       pixel_store_done,
    output logic                       weight_wr,
    output logic [ADDR_W-1:0]          weight_addr,
    output logic [DATA_W-1:0]          weight_data,
    output logic [$clog2(N_LAYER)-1:0] weight_layer_sel,
    output logic [N_LAYER-1:0]         weight_layer_done,
    output logic                       bias_wr,
    output logic [ADDR_W-1:0]          bias_addr,
    output logic [DATA_W-1:0]          bias_data,
    output logic [$clog2(N_LAYER)-1:0] bias_layer_sel,
    output logic [N_LAYER-1:0]         bias_layer_done,
    output logic                       all_store_done,
    output logic                       store_err
);

    logic [3:0]  tag;
    logic        pix_beat;
    logic        wgt_beat;
    logic        bia_beat;
    logic        soft_clr;
    logic        pix_err;
    logic        wgt_err;
    logic        bia_err;
    logic        pix_sel_unused;
    logic        unused_bits;

    assign tag      = awaddr[31:28];
    assign pix_beat = wvalid && (tag == TAG_PIXEL);
    assign wgt_beat = wvalid && (tag == TAG_WEIGHT);
    assign bia_beat = wvalid && (tag == TAG_BIAS);

`ifdef LAYER_STORE_SOFT_RESTART_EN
    assign soft_clr = wvalid && (tag == TAG_INTR);
`else
    assign soft_clr = 1'b0;
`endif

    assign unused_bits = &{1'b0, awaddr[27:0], wdata[31:DATA_W]};

    region_store_fsm #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_LAYER (1), .COUNTS (16'(PIXEL_NUM))
    ) u_pixel (
        .clk (clk), .rst (rst), .clr (soft_clr), .beat (pix_beat),
        .beat_data (wdata[DATA_W-1:0]),
        .wr (pixel_wr), .addr (pixel_addr), .data (pixel_data),
        .layer_sel (pix_sel_unused), .layer_done (pixel_store_done), .overflow (pix_err)
    );

    region_store_fsm #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_LAYER (N_LAYER), .COUNTS (WEIGHT_NUM)
    ) u_weight (
        .clk (clk), .rst (rst), .clr (soft_clr), .beat (wgt_beat),
        .beat_data (wdata[DATA_W-1:0]),
        .wr (weight_wr), .addr (weight_addr), .data (weight_data),
        .layer_sel (weight_layer_sel), .layer_done (weight_layer_done), .overflow (wgt_err)
    );

    region_store_fsm #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_LAYER (N_LAYER), .COUNTS (BIAS_NUM)
    ) u_bias (
        .clk (clk), .rst (rst), .clr (soft_clr), .beat (bia_beat),
        .beat_data (wdata[DATA_W-1:0]),
        .wr (bias_wr), .addr (bias_addr), .data (bias_data),
        .layer_sel (bias_layer_sel), .layer_done (bias_layer_done), .overflow (bia_err)
    );

    assign store_err      = pix_err | wgt_err | bia_err;
    assign all_store_done = pixel_store_done & (&weight_layer_done) & (&bias_layer_done);

endmodule

// File: tb/tb_layer_store_ctrl.sv
// tb/tb_layer_store_ctrl.sv - randomized beats checked every cycle against a word-count model of the three regions
module tb_layer_store_ctrl;

    localparam int DATA_W = 16, ADDR_W = 16, N_LAYER = 4, PIXEL_NUM = 3072;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wvalid = 1'b0;
    logic [31:0] awaddr = '0;
    logic [31:0] wdata = '0;

    logic              pixel_wr, pixel_store_done, weight_wr, bias_wr, all_store_done, store_err;
    logic [ADDR_W-1:0] pixel_addr, weight_addr, bias_addr;
    logic [DATA_W-1:0] pixel_data, weight_data, bias_data;
    logic [1:0]        weight_layer_sel, bias_layer_sel;
    logic [3:0]        weight_layer_done, bias_layer_done;

    layer_store_ctrl #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .N_LAYER (N_LAYER), .PIXEL_NUM (PIXEL_NUM)
    ) dut (
        .clk (clk), .rst (rst), .wvalid (wvalid), .awaddr (awaddr), .wdata (wdata),
        .pixel_wr (pixel_wr), .pixel_addr (pixel_addr), .pixel_data (pixel_data),
        .pixel_store_done (pixel_store_done),
        .weight_wr (weight_wr), .weight_addr (weight_addr), .weight_data (weight_data),
        .weight_layer_sel (weight_layer_sel), .weight_layer_done (weight_layer_done),
        .bias_wr (bias_wr), .bias_addr (bias_addr), .bias_data (bias_data),
        .bias_layer_sel (bias_layer_sel), .bias_layer_done (bias_layer_done),
        .all_store_done (all_store_done), .store_err (store_err)
    );

    always #5 clk = ~clk;

    int wcnt[4] = '{216, 1152, 2304, 4608};
    int bcnt[4] = '{8, 16, 32, 64};
    int wtot = 0, btot = 0;
    int acc_p = 0, acc_w = 0, acc_b = 0;
    bit m_err = 1'b0;
    int n_chk = 0, n_pass = 0;

    // A layer is complete once the region has accepted every word of it and all earlier layers
    function automatic logic [3:0] exp_done(input int acc, input int cnt[4]);
        int sum = 0;
        logic [3:0] d = '0;
        for (int i = 0; i < 4; i++) begin
            sum += cnt[i];
            d[i] = (acc >= sum);
        end
        return d;
    endfunction

    function automatic logic [1:0] exp_sel(input int acc, input int cnt[4]);
        logic [3:0] d = exp_done(acc, cnt);
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(d[i]);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input bit r, input bit v, input logic [3:0] tag);
        logic [31:0] d;
        bit ep, ew, eb;
        int ap = 0, aw = 0, ab = 0;
        @(negedge clk);
        d      = $urandom;
        rst    = r;
        wvalid = v;
        awaddr = {tag, 28'($urandom)};
        wdata  = d;
        ep = 0; ew = 0; eb = 0;
        if (r) begin
            acc_p = 0; acc_w = 0; acc_b = 0; m_err = 0;
        end else if (v) begin
            case (tag)
                4'h4: if (acc_p < PIXEL_NUM) begin ep = 1; ap = acc_p; acc_p++; end else m_err = 1;
                4'h8: if (acc_w < wtot) begin ew = 1; aw = acc_w; acc_w++; end else m_err = 1;
                4'h9: if (acc_b < btot) begin eb = 1; ab = acc_b; acc_b++; end else m_err = 1;
`ifdef LAYER_STORE_SOFT_RESTART_EN
                4'h2: begin acc_p = 0; acc_w = 0; acc_b = 0; m_err = 0; end
`endif
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        chk("pixel_wr", 32'(pixel_wr), 32'(ep));
        chk("pixel_addr", 32'(pixel_addr), ep ? 32'(ap) : 32'd0);
        chk("pixel_data", 32'(pixel_data), ep ? 32'(d[15:0]) : 32'd0);
        chk("pixel_store_done", 32'(pixel_store_done), 32'(acc_p >= PIXEL_NUM));
        chk("weight_wr", 32'(weight_wr), 32'(ew));
        chk("weight_addr", 32'(weight_addr), ew ? 32'(aw) : 32'd0);
        chk("weight_data", 32'(weight_data), ew ? 32'(d[15:0]) : 32'd0);
        chk("weight_layer_done", 32'(weight_layer_done), 32'(exp_done(acc_w, wcnt)));
        chk("weight_layer_sel", 32'(weight_layer_sel), 32'(exp_sel(acc_w, wcnt)));
        chk("bias_wr", 32'(bias_wr), 32'(eb));
        chk("bias_addr", 32'(bias_addr), eb ? 32'(ab) : 32'd0);
        chk("bias_data", 32'(bias_data), eb ? 32'(d[15:0]) : 32'd0);
        chk("bias_layer_done", 32'(bias_layer_done), 32'(exp_done(acc_b, bcnt)));
        chk("bias_layer_sel", 32'(bias_layer_sel), 32'(exp_sel(acc_b, bcnt)));
        chk("all_store_done", 32'(all_store_done),
            32'(acc_p >= PIXEL_NUM && acc_w >= wtot && acc_b >= btot));
        chk("store_err", 32'(store_err), 32'(m_err));
    endtask

    // Beat to a region, sometimes preceded by an idle cycle
    task automatic beat_gap(input logic [3:0] tag);
        if ($urandom_range(0, 7) == 0) step(0, 0, 4'h4);
        step(0, 1, tag);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4; i++) begin
            wtot += wcnt[i];
            btot += bcnt[i];
        end

        step(1, 0, 4'h0);
        step(1, 1, 4'h8);
        chk("reset_all_done", 32'(all_store_done), 32'd0);
        chk("reset_pixel_addr", 32'(pixel_addr), 32'd0);
        chk("reset_weight_wr", 32'(weight_wr), 32'd0);

        // Interleaved pixel / bias / foreign-tag traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: step(0, 1, 4'h4);
                1: step(0, 1, 4'h9);
                2: step(0, 1, 4'hF);
                3: step(0, 0, 4'h9);
                default: step(0, 1, 4'h4);
            endcase
        end

        // Reset part way through the pixel image
        step(1, 0, 4'h0);
        for (int i = 0; i < 100; i++) beat_gap(4'h4);
        step(1, 0, 4'h0);
        chk("restart_pixel_done", 32'(pixel_store_done), 32'd0);
        step(0, 1, 4'h4);
        chk("restart_pixel_wr", 32'(pixel_wr), 32'd1);
        chk("restart_pixel_addr", 32'(pixel_addr), 32'd0);

        // First weight layer, then the start and end of the second
        step(1, 0, 4'h0);
        for (int i = 0; i < 216; i++) beat_gap(4'h8);
        chk("w_layer0_last_addr", 32'(weight_addr), 32'd215);
        chk("w_layer0_done", 32'(weight_layer_done), 32'h1);
        chk("w_layer0_sel", 32'(weight_layer_sel), 32'd1);
        step(0, 1, 4'h8);
        chk("w_layer1_first_addr", 32'(weight_addr), 32'd216);
        for (int i = 0; i < 1151; i++) beat_gap(4'h8);
        chk("w_layer1_done", 32'(weight_layer_done), 32'h3);
        chk("w_layer1_sel", 32'(weight_layer_sel), 32'd2);

        // Fill everything in random order
        guard = 0;
        while ((acc_p < PIXEL_NUM || acc_w < wtot || acc_b < btot) && guard < 40000) begin
            int k = $urandom_range(0, 11);
            int r = $urandom_range(0, 2);
            guard++;
            if (k == 0) step(0, 0, 4'h4);
            else if (k == 1) step(0, 1, 4'hF);
            else begin
                if (r == 0 && acc_p >= PIXEL_NUM) r = 1;
                if (r == 1 && acc_w >= wtot) r = 2;
                if (r == 2 && acc_b >= btot) r = (acc_p < PIXEL_NUM) ? 0 : 1;
                step(0, 1, (r == 0) ? 4'h4 : (r == 1) ? 4'h8 : 4'h9);
            end
        end
        chk("fill_within_budget", 32'(guard < 40000), 32'd1);
        chk("full_all_done", 32'(all_store_done), 32'd1);
        chk("full_w_done", 32'(weight_layer_done), 32'hF);
        chk("full_b_sel", 32'(bias_layer_sel), 32'd3);
        step(0, 1, 4'h9);
        chk("overflow_bias_wr", 32'(bias_wr), 32'd0);
        chk("overflow_err", 32'(store_err), 32'd1);
        step(0, 1, 4'hF);

        step(0, 1, 4'h2);
`ifdef LAYER_STORE_SOFT_RESTART_EN
        chk("soft_restart_all_done", 32'(all_store_done), 32'd0);
        chk("soft_restart_err", 32'(store_err), 32'd0);
        step(0, 1, 4'h8);
        chk("soft_restart_w_addr", 32'(weight_addr), 32'd0);
`else
        chk("intr_ignored_all_done", 32'(all_store_done), 32'd1);
        chk("intr_ignored_err", 32'(store_err), 32'd1);
`endif
        for (int i = 0; i < 20; i++) step(0, 1, 4'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
